// File: rtl/collision_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : collision_scanner_pkg
// Purpose : World-map table formats, geometry widths and scanner states.
// Rev     : 1.0  initial release
// ============================================================================
package collision_scanner_pkg;

  localparam int N_ENTRIES = 16;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  localparam int X_W   = $clog2(SCREEN_W);
  localparam int Y_W   = $clog2(SCREEN_H);
  // One extra bit so coordinate + length sums never wrap.
  localparam int GEO_W = X_W + 1;
  localparam int IDX_W = $clog2(N_ENTRIES);

  typedef logic [GEO_W-1:0] geo_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [X_W-1:0] length;
    logic [Y_W-1:0] y_loc;
    logic [X_W-1:0] x_start;
  } ground_entry_t;

  typedef struct packed {
    logic [X_W-1:0] length;
    logic [X_W-1:0] x_loc;
    logic [Y_W-1:0] y_start;
  } fence_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_G = 2'd1,
    SCAN_F = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  function automatic geo_t widen_x(input logic [X_W-1:0] v);
    return geo_t'(v);
  endfunction

  function automatic geo_t widen_y(input logic [Y_W-1:0] v);
    return geo_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/collision_scanner_if.sv
`default_nettype none
// ============================================================================
// Module  : collision_scanner_if
// Purpose : Request, map-table and result bundle between map/motion and scanner.
// Rev     : 1.0  initial release
// ============================================================================
interface collision_scanner_if;
  import collision_scanner_pkg::*;

  logic                start;
  logic [X_W-1:0]      player_x;
  logic [X_W-1:0]      player_y;
  ground_entry_t       info_ground [N_ENTRIES];
  fence_entry_t        info_fence  [N_ENTRIES];
  logic                busy;
  logic                done;
  logic                on_ground;
  logic [Y_W-1:0]      ground_y;
  logic                hit_left;
  logic                hit_right;
  logic [X_W-1:0]      wall_left_x;
  logic [X_W-1:0]      wall_right_x;

  modport master (
    output start, player_x, player_y, info_ground, info_fence,
    input  busy, done, on_ground, ground_y, hit_left, hit_right,
           wall_left_x, wall_right_x
  );

  modport slave (
    input  start, player_x, player_y, info_ground, info_fence,
    output busy, done, on_ground, ground_y, hit_left, hit_right,
           wall_left_x, wall_right_x
  );

endinterface
`default_nettype wire

// File: rtl/collision_scanner_span_overlap.sv
`default_nettype none
// ============================================================================
// Module  : span_overlap
// Purpose : Inclusive interval intersection test [a_lo,a_hi] vs [b_lo,b_hi].
// Rev     : 1.0  initial release
// ============================================================================
module span_overlap
  import collision_scanner_pkg::*;
(
  input  geo_t a_lo,
  input  geo_t a_hi,
  input  geo_t b_lo,
  input  geo_t b_hi,
  output logic hit
);

  assign hit = (a_lo <= b_hi) && (b_lo <= a_hi);

endmodule
`default_nettype wire

// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
// Module  : collision_scanner
// Purpose : Walks ground then fence tables one entry per clock and reports
//           ground contact and nearest blocking fences for the player box.
// Rev     : 1.0  initial release
// ============================================================================
module collision_scanner
  import collision_scanner_pkg::*;
#(
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 32,
  parameter int SNAP     = 4,
  parameter int REACH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  collision_scanner_if.slave  bus
);

  scan_state_t r_state, w_state_next;
  idx_t        r_idx, w_idx_next;
  logic        w_accept, w_publish, w_busy, w_done;

  geo_t        r_px, r_py;

  logic            r_g_found, w_g_found_n;
  logic [Y_W-1:0]  r_g_y,     w_g_y_n;
  logic            r_l_found, w_l_found_n;
  logic [X_W-1:0]  r_l_x,     w_l_x_n;
  logic            r_r_found, w_r_found_n;
  logic [X_W-1:0]  r_r_x,     w_r_x_n;

  logic            r_on_ground, r_hit_left, r_hit_right;
  logic [Y_W-1:0]  r_ground_y;
  logic [X_W-1:0]  r_wall_left_x, r_wall_right_x;

  ground_entry_t w_g;
  fence_entry_t  w_f;
  geo_t          w_feet, w_right, w_bottom;
  geo_t          w_g_xs, w_g_xe, w_g_yl, w_f_ys, w_f_ye, w_f_x;
  logic          w_g_xhit, w_f_vhit, w_g_hit, w_l_hit, w_r_hit;

  assign w_g = bus.info_ground[r_idx];
  assign w_f = bus.info_fence[r_idx];

  assign w_feet   = r_py + geo_t'(PLAYER_H);
  assign w_right  = r_px + geo_t'(PLAYER_W - 1);
  assign w_bottom = r_py + geo_t'(PLAYER_H - 1);

  assign w_g_xs = widen_x(w_g.x_start);
  assign w_g_xe = widen_x(w_g.x_start) + widen_x(w_g.length);
  assign w_g_yl = widen_y(w_g.y_loc);
  assign w_f_ys = widen_y(w_f.y_start);
  assign w_f_ye = widen_y(w_f.y_start) + widen_x(w_f.length);
  assign w_f_x  = widen_x(w_f.x_loc);

  span_overlap u_ground_span (
    .a_lo (r_px),
    .a_hi (w_right),
    .b_lo (w_g_xs),
    .b_hi (w_g_xe),
    .hit  (w_g_xhit)
  );

  span_overlap u_fence_span (
    .a_lo (r_py),
    .a_hi (w_bottom),
    .b_lo (w_f_ys),
    .b_hi (w_f_ye),
    .hit  (w_f_vhit)
  );

  // Zero-length entries mark unused table slots.
  assign w_g_hit = (r_state == SCAN_G) && (w_g.length != '0) && w_g_xhit &&
                   (w_feet + geo_t'(SNAP) >= w_g_yl) && (w_feet <= w_g_yl);

  assign w_l_hit = (r_state == SCAN_F) && (w_f.length != '0) && w_f_vhit &&
                   (w_f_x < r_px) && (w_f_x + geo_t'(REACH) >= r_px);

  assign w_r_hit = (r_state == SCAN_F) && (w_f.length != '0) && w_f_vhit &&
                   (w_f_x > w_right) && (w_f_x <= w_right + geo_t'(REACH));

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_accept     = 1'b0;
    w_publish    = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = SCAN_G;
          w_idx_next   = '0;
        end
      end
      SCAN_G: begin
        if (r_idx == idx_t'(N_ENTRIES - 1)) begin
          w_state_next = SCAN_F;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + idx_t'(1);
        end
      end
      SCAN_F: begin
        if (r_idx == idx_t'(N_ENTRIES - 1)) begin
          w_state_next = DONE;
          w_idx_next   = '0;
          w_publish    = 1'b1;
        end else begin
          w_idx_next = r_idx + idx_t'(1);
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Strict comparisons keep the earliest entry on ties.
  always_comb begin
    w_g_found_n = r_g_found;
    w_g_y_n     = r_g_y;
    w_l_found_n = r_l_found;
    w_l_x_n     = r_l_x;
    w_r_found_n = r_r_found;
    w_r_x_n     = r_r_x;
    if (w_accept) begin
      w_g_found_n = 1'b0;
      w_g_y_n     = '0;
      w_l_found_n = 1'b0;
      w_l_x_n     = '0;
      w_r_found_n = 1'b0;
      w_r_x_n     = '0;
    end else begin
      if (w_g_hit && (!r_g_found || (w_g.y_loc < r_g_y))) begin
        w_g_found_n = 1'b1;
        w_g_y_n     = w_g.y_loc;
      end
      if (w_l_hit && (!r_l_found || (w_f.x_loc > r_l_x))) begin
        w_l_found_n = 1'b1;
        w_l_x_n     = w_f.x_loc;
      end
      if (w_r_hit && (!r_r_found || (w_f.x_loc < r_r_x))) begin
        w_r_found_n = 1'b1;
        w_r_x_n     = w_f.x_loc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_px           <= '0;
      r_py           <= '0;
      r_g_found      <= 1'b0;
      r_g_y          <= '0;
      r_l_found      <= 1'b0;
      r_l_x          <= '0;
      r_r_found      <= 1'b0;
      r_r_x          <= '0;
      r_on_ground    <= 1'b0;
      r_ground_y     <= '0;
      r_hit_left     <= 1'b0;
      r_hit_right    <= 1'b0;
      r_wall_left_x  <= '0;
      r_wall_right_x <= '0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      if (w_accept) begin
        r_px <= widen_x(bus.player_x);
        r_py <= widen_x(bus.player_y);
      end
      r_g_found <= w_g_found_n;
      r_g_y     <= w_g_y_n;
      r_l_found <= w_l_found_n;
      r_l_x     <= w_l_x_n;
      r_r_found <= w_r_found_n;
      r_r_x     <= w_r_x_n;
      // Publish from the next-state values so the final fence entry is included.
      if (w_publish) begin
        r_on_ground    <= w_g_found_n;
        r_ground_y     <= w_g_y_n;
        r_hit_left     <= w_l_found_n;
        r_hit_right    <= w_r_found_n;
        r_wall_left_x  <= w_l_x_n;
        r_wall_right_x <= w_r_x_n;
      end
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.on_ground    = r_on_ground;
  assign bus.ground_y     = r_ground_y;
  assign bus.hit_left     = r_hit_left;
  assign bus.hit_right    = r_hit_right;
  assign bus.wall_left_x  = r_wall_left_x;
  assign bus.wall_right_x = r_wall_right_x;

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_collision_scanner
// Purpose : Directed self-checking bench for collision_scanner on a small map.
// Rev     : 1.0  initial release
// ============================================================================
module tb_collision_scanner;
  import collision_scanner_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  int   done_cnt;
  int   first_done;
  int   busy_gap;

  collision_scanner_if bus ();

  collision_scanner #(
    .PLAYER_W (16),
    .PLAYER_H (32),
    .SNAP     (4),
    .REACH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input string tag, input int og, input int gy,
                            input int hl, input int hr, input int wl, input int wr);
    chk({tag, ".on_ground"},    32'(bus.on_ground),    og);
    chk({tag, ".ground_y"},     32'(bus.ground_y),     gy);
    chk({tag, ".hit_left"},     32'(bus.hit_left),     hl);
    chk({tag, ".hit_right"},    32'(bus.hit_right),    hr);
    chk({tag, ".wall_left_x"},  32'(bus.wall_left_x),  wl);
    chk({tag, ".wall_right_x"}, 32'(bus.wall_right_x), wr);
  endtask

  // Called #1 after an edge; start is high for the current cycle (cycle 0).
  // Returns #1 after the edge that opens the DONE cycle.
  task automatic do_scan(input string tag, input int px, input int py);
    bus.player_x = 10'(px);
    bus.player_y = 10'(py);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 33);
  endtask

  task automatic end_scan(input string tag);
    @(posedge clk); #1;
    chk({tag, ".done_falls"}, 32'(bus.done), 0);
    chk({tag, ".idle"},       32'(bus.busy), 0);
  endtask

  function automatic ground_entry_t mk_g(input int xs, input int y, input int len);
    ground_entry_t e;
    e.x_start = 10'(xs);
    e.y_loc   = 9'(y);
    e.length  = 10'(len);
    return e;
  endfunction

  function automatic fence_entry_t mk_f(input int ys, input int x, input int len);
    fence_entry_t e;
    e.y_start = 9'(ys);
    e.x_loc   = 10'(x);
    e.length  = 10'(len);
    return e;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start    = 1'b0;
    bus.player_x = '0;
    bus.player_y = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      bus.info_ground[i] = '0;
      bus.info_fence[i]  = '0;
    end
    // Ground: floor, ledge, unused slot that would otherwise win, high ledge.
    bus.info_ground[0] = mk_g(0,   430, 639);
    bus.info_ground[1] = mk_g(100, 380, 50);
    bus.info_ground[2] = mk_g(400, 250, 0);
    bus.info_ground[3] = mk_g(390, 252, 40);
    // Fences: nearer candidates first so a keep-last scan is caught.
    bus.info_fence[0] = mk_f(380, 102, 50);
    bus.info_fence[1] = mk_f(380, 219, 50);
    bus.info_fence[2] = mk_f(380, 101, 50);
    bus.info_fence[3] = mk_f(380, 220, 50);
    bus.info_fence[4] = mk_f(100, 500, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    expect_res("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_scan("floor", 300, 398);
    expect_res("floor", 1, 430, 0, 0, 0, 0);
    end_scan("floor");

    // Start repeated in cycle 5 must be dropped.
    bus.player_x = 10'd110;
    bus.player_y = 10'd348;
    bus.start    = 1'b1;
    done_cnt = 0; first_done = 0; busy_gap = 0;
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      bus.start = (n == 5);
      if (n <= 33 && !bus.busy) busy_gap++;
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
    end
    chk("restart.done_count", 32'(done_cnt), 1);
    chk("restart.done_cycle", 32'(first_done), 33);
    chk("restart.busy_gaps",  32'(busy_gap), 0);
    expect_res("ledge", 1, 380, 0, 0, 0, 0);

    do_scan("ledge_edge", 150, 348);
    expect_res("ledge_edge", 1, 380, 0, 0, 0, 0);
    end_scan("ledge_edge");

    do_scan("left", 103, 390);
    expect_res("left", 0, 0, 1, 0, 102, 0);
    end_scan("left");

    do_scan("left_reach", 104, 390);
    expect_res("left_reach", 0, 0, 1, 0, 102, 0);
    end_scan("left_reach");

    do_scan("left_far", 105, 390);
    expect_res("left_far", 0, 0, 0, 0, 0, 0);
    end_scan("left_far");

    do_scan("right", 203, 390);
    expect_res("right", 0, 0, 0, 1, 0, 219);
    end_scan("right");

    // Async reset at cycle 10 of a scan.
    bus.player_x = 10'd300;
    bus.player_y = 10'd398;
    bus.start    = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midreset.busy", 32'(bus.busy), 0);
    expect_res("midreset", 0, 0, 0, 0, 0, 0);
    done_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    chk("midreset.no_done", 32'(done_cnt), 0);

    do_scan("after_reset", 300, 398);
    expect_res("after_reset", 1, 430, 0, 0, 0, 0);
    // Start held through DONE: dropped there, accepted in the following IDLE cycle.
    bus.player_x = 10'd204;
    bus.player_y = 10'd390;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    chk("b2b.idle_gap", 32'(bus.busy), 0);
    do_scan("right_reach", 204, 390);
    expect_res("right_reach", 0, 0, 0, 1, 0, 220);
    end_scan("right_reach");

    do_scan("right_far", 205, 390);
    expect_res("right_far", 0, 0, 0, 0, 0, 0);
    end_scan("right_far");

    do_scan("air", 300, 200);
    expect_res("air", 0, 0, 0, 0, 0, 0);
    end_scan("air");

    do_scan("high_ledge", 400, 218);
    expect_res("high_ledge", 1, 252, 0, 0, 0, 0);
    end_scan("high_ledge");

    do_scan("snap_edge", 400, 216);
    expect_res("snap_edge", 1, 252, 0, 0, 0, 0);
    end_scan("snap_edge");

    do_scan("snap_out", 400, 215);
    expect_res("snap_out", 0, 0, 0, 0, 0, 0);
    end_scan("snap_out");

    do_scan("unused_fence", 502, 90);
    expect_res("unused_fence", 0, 0, 0, 0, 0, 0);
    end_scan("unused_fence");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
